// File: rtl/pacman_tick_pkg.sv
// Shared definitions for the Pacman game-tick Avalon-MM initiator:
// FSM states, timer register map, control words and the output decode.
package pacman_tick_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WR_P0       = 4'd1,
        ST_WR_P1       = 4'd2,
        ST_WR_P2       = 4'd3,
        ST_WR_P3       = 4'd4,
        ST_WR_CTRL     = 4'd5,
        ST_RUN         = 4'd6,
        ST_RD_STATUS   = 4'd7,
        ST_CAP_STATUS  = 4'd8,
        ST_CLR_STATUS  = 4'd9,
        ST_WR_STOP     = 4'd10,
        ST_WR_CLR_STOP = 4'd11
    } state_e;

    // Timer register indices
    localparam logic [3:0] REG_STATUS  = 4'd0;
    localparam logic [3:0] REG_CONTROL = 4'd1;
    localparam logic [3:0] REG_PERIOD0 = 4'd2;
    localparam logic [3:0] REG_PERIOD1 = 4'd3;
    localparam logic [3:0] REG_PERIOD2 = 4'd4;
    localparam logic [3:0] REG_PERIOD3 = 4'd5;

    // Status / control bit positions
    localparam int unsigned STATUS_TO_BIT  = 0;
    localparam int unsigned CTRL_ITO_BIT   = 0;
    localparam int unsigned CTRL_CONT_BIT  = 1;
    localparam int unsigned CTRL_START_BIT = 2;
    localparam int unsigned CTRL_STOP_BIT  = 3;

    // Control words: continuous interrupting run (0x0007), and stop (0x0008)
    localparam logic [15:0] CTRL_RUN  = (16'd1 << CTRL_ITO_BIT) |
                                        (16'd1 << CTRL_CONT_BIT) |
                                        (16'd1 << CTRL_START_BIT);
    localparam logic [15:0] CTRL_STOP = (16'd1 << CTRL_STOP_BIT);

    // Shortest period that still leaves room for the 4-cycle service loop
    localparam logic [31:0] MIN_PERIOD = 32'd8;

    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        tick;
        logic        busy;
    } bus_out_t;

    // Timer load value: clamp to the minimum period, then subtract one
    // because the timer counts L..0 (L+1 cycles per timeout).
    function automatic logic [31:0] load_value(input logic [31:0] period);
        logic [31:0] eff;
        if (period < MIN_PERIOD) begin
            eff = MIN_PERIOD;
        end else begin
            eff = period;
        end
        return eff - 32'd1;
    endfunction

    // Bus/handshake outputs as a pure function of FSM state (and load value).
    function automatic bus_out_t decode_outputs(input state_e st, input logic [31:0] load);
        bus_out_t o;
        o = '{cs: 1'b0, wn: 1'b1, addr: REG_STATUS, wdata: 16'h0000, tick: 1'b0, busy: 1'b1};
        case (st)
            ST_IDLE:        o.busy = 1'b0;
            ST_WR_P0:       begin o.cs = 1'b1; o.wn = 1'b0; o.addr = REG_PERIOD0; o.wdata = load[15:0];  end
            ST_WR_P1:       begin o.cs = 1'b1; o.wn = 1'b0; o.addr = REG_PERIOD1; o.wdata = load[31:16]; end
            ST_WR_P2:       begin o.cs = 1'b1; o.wn = 1'b0; o.addr = REG_PERIOD2; end
            ST_WR_P3:       begin o.cs = 1'b1; o.wn = 1'b0; o.addr = REG_PERIOD3; end
            ST_WR_CTRL:     begin o.cs = 1'b1; o.wn = 1'b0; o.addr = REG_CONTROL; o.wdata = CTRL_RUN;  end
            ST_RUN:         o.cs = 1'b0;
            ST_RD_STATUS:   o.cs = 1'b1;
            ST_CAP_STATUS:  o.cs = 1'b0;
            ST_CLR_STATUS:  begin o.cs = 1'b1; o.wn = 1'b0; o.tick = 1'b1; end
            ST_WR_STOP:     begin o.cs = 1'b1; o.wn = 1'b0; o.addr = REG_CONTROL; o.wdata = CTRL_STOP; end
            ST_WR_CLR_STOP: begin o.cs = 1'b1; o.wn = 1'b0; end
            default:        o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pacman_tick_master.sv
// Avalon-MM initiator that programs the interval timer, services its
// timeout interrupt and produces a one-cycle game tick per timeout.
module pacman_tick_master
    import pacman_tick_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int TICK_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    output logic [3:0]          avm_address,
    output logic                avm_chipselect,
    output logic                avm_write_n,
    output logic [15:0]         avm_writedata,
    input  logic [15:0]         avm_readdata,
    input  logic                irq,
    output logic                tick,
    output logic [TICK_W-1:0]   tick_count,
    output logic                busy
);

    state_e              r_state;
    bus_out_t            r_out;
    logic [31:0]         r_load;
    logic [TICK_W-1:0]   r_tick_count;
    logic                r_stop_pend;

    state_e              w_next;
    logic                w_start_accept;
    logic [31:0]         w_period32;
    logic [31:0]         w_load_next;
    bus_out_t            w_out;
    logic                w_unused;

    // Only the TO flag of the status word matters here.
    assign w_unused       = ^avm_readdata[15:1];

    // Periods wider than the two programmable halfwords are truncated.
    assign w_period32     = 32'(period);
    assign w_start_accept = (r_state == ST_IDLE) && start;

    // Next-state selection for the programming / service / stop sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_WR_P0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR_P0:      w_next = ST_WR_P1;
            ST_WR_P1:      w_next = ST_WR_P2;
            ST_WR_P2:      w_next = ST_WR_P3;
            ST_WR_P3:      w_next = ST_WR_CTRL;
            ST_WR_CTRL:    w_next = ST_RUN;
            ST_RUN: begin
                if (r_stop_pend) begin
                    w_next = ST_WR_STOP;
                end else if (irq) begin
                    w_next = ST_RD_STATUS;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_RD_STATUS:  w_next = ST_CAP_STATUS;
            ST_CAP_STATUS: begin
                // TO clear means a spurious interrupt: go back without a tick
                if (avm_readdata[STATUS_TO_BIT]) begin
                    w_next = ST_CLR_STATUS;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_CLR_STATUS:  w_next = ST_RUN;
            ST_WR_STOP:     w_next = ST_WR_CLR_STOP;
            ST_WR_CLR_STOP: w_next = ST_IDLE;
            default:        w_next = ST_IDLE;
        endcase
    end

    // Load value for the upcoming state, refreshed on an accepted start
    always_comb begin
        if (w_start_accept) begin
            w_load_next = load_value(w_period32);
        end else begin
            w_load_next = r_load;
        end
    end

    // Output decode of the next state so the outputs come straight from flops
    always_comb begin
        w_out = decode_outputs(w_next, w_load_next);
    end

    // State, registered outputs, load value, tick counter and pending stop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_out        <= '{cs: 1'b0, wn: 1'b1, addr: 4'd0, wdata: 16'h0000, tick: 1'b0, busy: 1'b0};
            r_load       <= 32'd0;
            r_tick_count <= '0;
            r_stop_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= w_out;
            r_load  <= w_load_next;

            if (w_start_accept) begin
                r_tick_count <= '0;
            end else if (r_state == ST_CLR_STATUS) begin
                r_tick_count <= r_tick_count + TICK_W'(1);
            end else begin
                r_tick_count <= r_tick_count;
            end

            if (w_start_accept) begin
                r_stop_pend <= 1'b0;
            end else if ((r_state != ST_IDLE) && stop) begin
                r_stop_pend <= 1'b1;
            end else begin
                r_stop_pend <= r_stop_pend;
            end
        end
    end

    assign avm_address    = r_out.addr;
    assign avm_chipselect = r_out.cs;
    assign avm_write_n    = r_out.wn;
    assign avm_writedata  = r_out.wdata;
    assign tick           = r_out.tick;
    assign busy           = r_out.busy;
    assign tick_count     = r_tick_count;

endmodule
